// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one DMEM/MMIO slave port
// between NUM_MASTERS requesters using a req/ack handshake on both sides.
// All outputs are registered.
// Optional feature macro: MEM_BUS_ARB_TIMEOUT_EN. When it is defined, an
// access that receives no s_ack within TIMEOUT_CYCLES cycles ends with an
// m_ack carrying m_err=1.
module mem_bus_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_ack,
    output logic                              m_err,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              s_req,
    output logic                              s_we,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_ack,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic                              busy,
    output logic [$clog2(NUM_MASTERS)-1:0]    grant_id
);

    localparam int GW = $clog2(NUM_MASTERS);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [GW-1:0]     winner;
    logic [GW-1:0]     scan_idx;
    logic [NUM_MASTERS-1:0] grant_onehot;
    logic              any_req;
    logic              access_timeout;

    assign any_req = |m_req;

    // Round-robin scan starting just after the last grant; scanning from the
    // farthest offset down means the nearest requester overwrites the others.
    always_comb begin
        winner   = grant_id;
        scan_idx = '0;
        for (int off = NUM_MASTERS; off >= 1; off--) begin
            scan_idx = GW'((int'(grant_id) + off) % NUM_MASTERS);
            if (m_req[scan_idx]) begin
                winner = scan_idx;
            end
        end
    end

    // One-hot acknowledge vector for the master currently holding the grant.
    always_comb begin
        grant_onehot           = '0;
        grant_onehot[grant_id] = 1'b1;
    end

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] timeout_cnt;

    assign access_timeout = (timeout_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Counts ACCESS cycles without s_ack; cleared while idle so every access starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt <= '0;
        end else if (state == IDLE) begin
            timeout_cnt <= '0;
        end else if (state == ACCESS && !s_ack) begin
            timeout_cnt <= timeout_cnt + CW'(1);
        end
    end
`else
    assign access_timeout = 1'b0;
    assign m_err          = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; s_ack takes priority over a simultaneous timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = ACCESS;
            ACCESS:  if (s_ack || access_timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs: grant capture in IDLE, completion capture in ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_id <= GW'(NUM_MASTERS - 1);
            s_req    <= 1'b0;
            s_we     <= 1'b0;
            s_addr   <= '0;
            s_wdata  <= '0;
            m_ack    <= '0;
            m_rdata  <= '0;
            busy     <= 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            m_err    <= 1'b0;
`endif
        end else begin
            m_ack <= '0;
            busy  <= (state_next != IDLE);
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            m_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_id <= winner;
                        s_req    <= 1'b1;
                        s_we     <= m_we[winner];
                        s_addr   <= m_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        s_wdata  <= m_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ACCESS: begin
                    if (s_ack) begin
                        m_rdata <= s_rdata;
                        s_req   <= 1'b0;
                        m_ack   <= grant_onehot;
                    end else if (access_timeout) begin
                        m_rdata <= '0;
                        s_req   <= 1'b0;
                        m_ack   <= grant_onehot;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                        m_err   <= 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
